rpsc_interlock_core: RTL and testbench

Interlock and power-up sequencer for the RF power supply controller (RPSC) of a tetrode amplifier. Field inputs are synchronised, then sampled on a divided-clock tick. The core enables the supply stages in order: fan, cathode, grid-1, anode, grid-2, driver amp, RF. Any latched fault or open interlock drops the whole chain. The core sits directly under the FPGA top level, between the board I/O pins and the lamp/relay drivers.

---
 rtl/rpsc_pkg.sv | 27 ++
 rtl/rpsc_interlock_core_sync_ff.sv | 23 ++
 rtl/rpsc_interlock_core_tick_gen.sv | 21 ++
 rtl/rpsc_interlock_core.sv | 129 ++++++++++++
 tb/tb_rpsc_interlock_core.sv | 158 +++++++++++++++
 5 files changed

// File: rtl/rpsc_pkg.sv
// Shared definitions for the RPSC interlock core: field-input bit positions
// and the ordered list of supply stages.
package rpsc_pkg;

    localparam int ILK_CARD_POS        = 0;
    localparam int ILK_AIR_GRID        = 1;
    localparam int ILK_AIR_AN          = 2;
    localparam int ILK_WATER_HEAT_EXCH = 3;
    localparam int ILK_WATER_AN        = 4;
    localparam int ILK_DOOR_PAMP       = 5;
    localparam int ILK_GR_SW           = 6;
    localparam int ILK_HV_CONNECTOR    = 7;

    localparam int FLT_I_CA_HIGH       = 0;
    localparam int FLT_I_G1_HIGH       = 1;
    localparam int FLT_G1_PS_FAULT     = 2;
    localparam int FLT_AN_PS_FAULT     = 3;
    localparam int FLT_I_AN_HIGH_6A    = 4;
    localparam int FLT_G2_PS_FAULT     = 5;
    localparam int FLT_TEMP_DR_AMP     = 6;
    localparam int FLT_DC_PS_LOW       = 7;

    localparam int NUM_STAGES = 7;

    typedef enum logic [2:0] {FAN, CA, G1, AN, G2, DRAC, RF} stage_t;

endpackage

// File: rtl/rpsc_interlock_core_sync_ff.sv
// Two-flop synchroniser for asynchronous field inputs; both flops clear on reset.
module sync_ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/rpsc_interlock_core_tick_gen.sv
// Free-running divider; tick is high for the one cycle in which the count wraps.
module tick_gen #(
    parameter int DIV = 50
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam logic [15:0] LAST = 16'(DIV - 1);

    logic [15:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) count <= '0;
        else     count <= (count == LAST) ? '0 : count + 16'd1;
    end

    assign tick = (count == LAST);

endmodule

// File: rtl/rpsc_interlock_core.sv
// RPSC interlock and power-up sequencer: brings the tetrode supply stages up in
// order on divided-clock ticks and drops the whole chain on any fault or open interlock.
module rpsc_interlock_core
    import rpsc_pkg::*;
#(
    parameter int DIV            = 50,
    parameter int CA_DELAY_TICKS = 1000
) (
    input  logic       sys_clk50,
    input  logic       i_C2_RLY_RESET,
    input  logic [7:0] i_ILK,
    input  logic       i_C2_RLY_EM,
    input  logic       i_FAN_ACT,
    input  logic       i_CA_PS_ACT,
    input  logic       i_G1_PS_ACT,
    input  logic       i_AN_PS_ACT,
    input  logic       i_G2_PS_ACT,
    input  logic       i_DR_AMP,
    input  logic       i_OT_AN_Ready,
    input  logic       i_U_CA_LOW,
    input  logic       i_U_G1_LOW,
    input  logic       i_U_AN_LOW,
    input  logic [7:0] i_FLT,
    input  logic       i_I_AN_HIGH_5A,
    input  logic       i_TUNE_OK_Delayed_BAR,
    input  logic       i_LA_TEST,
    output logic       o_FAN_ON,
    output logic       o_CA_ON,
    output logic       o_C2_RLY_G1,
    output logic       o_C2_RLY_AN,
    output logic       o_C2_RLY_G2,
    output logic       o_C2_RLY_DRAC,
    output logic       o_TH_AN_Ready,
    output logic       o_RF_PERM_BAR,
    output logic       o_RF_RED_BAR,
    output logic [7:0] o_LA_ILK,
    output logic [7:0] o_LA_FLT,
    output logic       o_LA_EM,
    output logic       o_LA_CA_Delay
);

    localparam int DW = (CA_DELAY_TICKS < 1) ? 1 : $clog2(CA_DELAY_TICKS + 1);
    localparam logic [DW-1:0] DELAY_MAX = DW'(CA_DELAY_TICKS);

    logic clk, rst;
    assign clk = sys_clk50;
    assign rst = i_C2_RLY_RESET;

    logic [29:0] raw, syn;
    logic [7:0]  ilk, flt;
    logic        em, fan_act, ca_act, g1_act, an_act, g2_act, dr_amp, an_ready;
    logic        u_ca_low, u_g1_low, u_an_low, an_high_5a, tune_bar, la_test;

    assign raw = {i_ILK, i_C2_RLY_EM, i_FAN_ACT, i_CA_PS_ACT, i_G1_PS_ACT, i_AN_PS_ACT,
                  i_G2_PS_ACT, i_DR_AMP, i_OT_AN_Ready, i_U_CA_LOW, i_U_G1_LOW, i_U_AN_LOW,
                  i_FLT, i_I_AN_HIGH_5A, i_TUNE_OK_Delayed_BAR, i_LA_TEST};

    sync_ff #(.WIDTH(30)) u_sync (.clk(clk), .rst(rst), .d(raw), .q(syn));

    assign {ilk, em, fan_act, ca_act, g1_act, an_act, g2_act, dr_amp, an_ready,
            u_ca_low, u_g1_low, u_an_low, flt, an_high_5a, tune_bar, la_test} = syn;

    logic tick;
    tick_gen #(.DIV(DIV)) u_tick (.clk(clk), .rst(rst), .tick(tick));

    logic [NUM_STAGES-1:0] stage, stage_next;
    logic [7:0]            flt_latch, flt_next;
    logic [DW-1:0]         delay_cnt;
    logic                  delay_done, ok;

    assign delay_done = (delay_cnt == DELAY_MAX);

    // A fault seen on this tick already counts against ok, so it beats any stage request.
    always_comb begin
        flt_next         = flt_latch | flt;
        ok               = (&ilk) & ~em & (flt_next == 8'h00);
        stage_next       = '0;
        stage_next[FAN]  = ok;
        stage_next[CA]   = ok & stage[FAN] & fan_act;
        stage_next[G1]   = ok & stage[CA] & delay_done & ~u_ca_low;
        stage_next[AN]   = ok & stage[G1] & g1_act & ~u_g1_low & an_ready;
        stage_next[G2]   = ok & stage[AN] & an_act & ~u_an_low;
        stage_next[DRAC] = ok & stage[G2] & g2_act;
        stage_next[RF]   = ok & stage[DRAC] & dr_amp & ~tune_bar;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage         <= '0;
            flt_latch     <= '0;
            delay_cnt     <= '0;
            o_RF_PERM_BAR <= 1'b1;
        end else if (tick) begin
            stage         <= stage_next;
            flt_latch     <= flt_next;
            o_RF_PERM_BAR <= ~stage_next[RF];
            if (!stage[CA] || !ca_act)
                delay_cnt <= '0;
            else if (!delay_done)
                delay_cnt <= delay_cnt + 1'b1;
        end
    end

    // Lamps and the reduced-RF flag track the synchronised inputs every cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_LA_ILK      <= '0;
            o_LA_FLT      <= '0;
            o_LA_EM       <= 1'b0;
            o_LA_CA_Delay <= 1'b0;
            o_RF_RED_BAR  <= 1'b1;
        end else begin
            o_LA_ILK      <= la_test ? 8'hFF : ~ilk;
            o_LA_FLT      <= la_test ? 8'hFF : flt_latch;
            o_LA_EM       <= la_test | em;
            o_LA_CA_Delay <= la_test | (stage[CA] & ca_act & ~delay_done);
            o_RF_RED_BAR  <= ~(stage[RF] & an_high_5a);
        end
    end

    assign o_FAN_ON      = stage[FAN];
    assign o_CA_ON       = stage[CA];
    assign o_C2_RLY_G1   = stage[G1];
    assign o_C2_RLY_AN   = stage[AN];
    assign o_C2_RLY_G2   = stage[G2];
    assign o_C2_RLY_DRAC = stage[DRAC];
    assign o_TH_AN_Ready = stage[G1];

endmodule

// File: tb/tb_rpsc_interlock_core.sv
// Directed self-checking bench for rpsc_interlock_core (DIV=4, CA_DELAY_TICKS=3).
module tb_rpsc_interlock_core;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] ilk, flt;
    logic       em, fan_act, ca_act, g1_act, an_act, g2_act, dr_amp, an_ready;
    logic       u_ca, u_g1, u_an, an5a, tune_bar, la_test;
    logic       fan_on, ca_on, g1_on, an_on, g2_on, drac_on, th_ready, perm_bar, red_bar;
    logic [7:0] la_ilk, la_flt;
    logic       la_em, la_ca_delay;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rpsc_interlock_core #(.DIV(4), .CA_DELAY_TICKS(3)) dut (
        .sys_clk50(clk), .i_C2_RLY_RESET(rst), .i_ILK(ilk), .i_C2_RLY_EM(em),
        .i_FAN_ACT(fan_act), .i_CA_PS_ACT(ca_act), .i_G1_PS_ACT(g1_act),
        .i_AN_PS_ACT(an_act), .i_G2_PS_ACT(g2_act), .i_DR_AMP(dr_amp),
        .i_OT_AN_Ready(an_ready), .i_U_CA_LOW(u_ca), .i_U_G1_LOW(u_g1), .i_U_AN_LOW(u_an),
        .i_FLT(flt), .i_I_AN_HIGH_5A(an5a), .i_TUNE_OK_Delayed_BAR(tune_bar),
        .i_LA_TEST(la_test),
        .o_FAN_ON(fan_on), .o_CA_ON(ca_on), .o_C2_RLY_G1(g1_on), .o_C2_RLY_AN(an_on),
        .o_C2_RLY_G2(g2_on), .o_C2_RLY_DRAC(drac_on), .o_TH_AN_Ready(th_ready),
        .o_RF_PERM_BAR(perm_bar), .o_RF_RED_BAR(red_bar), .o_LA_ILK(la_ilk),
        .o_LA_FLT(la_flt), .o_LA_EM(la_em), .o_LA_CA_Delay(la_ca_delay)
    );

    // Bit 6 = fan ... bit 0 = rf, with rf taken from the active-low permit.
    logic [6:0] en_vec;
    assign en_vec = {fan_on, ca_on, g1_on, an_on, g2_on, drac_on, ~perm_bar};

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] ilk_v, input logic em_v, input logic [7:0] flt_v,
                                 input logic an5a_v, input logic test_v);
        @(negedge clk);
        ilk = ilk_v; em = em_v; flt = flt_v; an5a = an5a_v; la_test = test_v;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Follows a power-up from idle and checks the tick spacing between stages.
    task automatic powerUp(input string tag);
        int rise[7];
        logic delay_lamp;
        delay_lamp = 1'b0;
        for (int i = 0; i < 7; i++) rise[i] = -1;
        for (int c = 0; c < 400 && rise[6] < 0; c++) begin
            @(negedge clk);
            for (int i = 0; i < 7; i++)
                if (rise[i] < 0 && en_vec[6-i]) rise[i] = c;
            if (rise[1] >= 0 && rise[2] < 0 && c == rise[1] + 2) delay_lamp = la_ca_delay;
        end
        checkOutput({tag, "_reached_rf"}, 32'(rise[6] >= 0), 1);
        checkOutput({tag, "_fan_to_ca"},   32'(rise[1] - rise[0]), 4);
        checkOutput({tag, "_ca_to_g1"},    32'(rise[2] - rise[1]), 16);
        checkOutput({tag, "_g1_to_an"},    32'(rise[3] - rise[2]), 4);
        checkOutput({tag, "_an_to_g2"},    32'(rise[4] - rise[3]), 4);
        checkOutput({tag, "_g2_to_drac"},  32'(rise[5] - rise[4]), 4);
        checkOutput({tag, "_drac_to_rf"},  32'(rise[6] - rise[5]), 4);
        checkOutput({tag, "_delay_lamp"},  32'(delay_lamp), 1);
        waitCycles(2);
        checkOutput({tag, "_all_on"},      32'(en_vec), 32'h7F);
        checkOutput({tag, "_th_ready"},    32'(th_ready), 1);
        checkOutput({tag, "_red_bar"},     32'(red_bar), 1);
        checkOutput({tag, "_delay_off"},   32'(la_ca_delay), 0);
    endtask

    // Waits (bounded) for the fan to drop, then checks the whole chain dropped with it.
    task automatic expectDrop(input string tag);
        int c;
        c = 0;
        while (fan_on && c < 40) begin
            @(negedge clk);
            c++;
        end
        checkOutput({tag, "_fan_dropped"}, 32'(fan_on), 0);
        checkOutput({tag, "_chain_off"},   32'(en_vec), 0);
    endtask

    initial begin
        rst = 1'b1;
        ilk = 8'hFF; em = 1'b0; flt = 8'h00; an5a = 1'b0; la_test = 1'b0;
        fan_act = 1'b1; ca_act = 1'b1; g1_act = 1'b1; an_act = 1'b1; g2_act = 1'b1;
        dr_amp = 1'b1; an_ready = 1'b1; u_ca = 1'b0; u_g1 = 1'b0; u_an = 1'b0;
        tune_bar = 1'b0;

        waitCycles(3);
        checkOutput("rst_enables", 32'(en_vec), 0);
        checkOutput("rst_th_ready", 32'(th_ready), 0);
        checkOutput("rst_perm_bar", 32'(perm_bar), 1);
        checkOutput("rst_red_bar", 32'(red_bar), 1);
        checkOutput("rst_lamps", {14'd0, la_ilk, la_flt, la_em, la_ca_delay}, 0);

        @(negedge clk) rst = 1'b0;
        powerUp("pwr1");

        applyStimulus(8'hFF, 1'b0, 8'h00, 1'b1, 1'b0);
        waitCycles(5);
        checkOutput("red_active", 32'(red_bar), 0);
        checkOutput("red_perm_held", 32'(perm_bar), 0);
        applyStimulus(8'hFF, 1'b0, 8'h00, 1'b0, 1'b0);
        waitCycles(5);
        checkOutput("red_released", 32'(red_bar), 1);

        applyStimulus(8'hFF, 1'b0, 8'h10, 1'b0, 1'b0);
        waitCycles(3);
        applyStimulus(8'hFF, 1'b0, 8'h00, 1'b0, 1'b0);
        expectDrop("flt");
        waitCycles(3);
        checkOutput("flt_lamp", 32'(la_flt), 32'h10);
        waitCycles(50);
        checkOutput("flt_hold_chain", 32'(en_vec), 0);
        checkOutput("flt_hold_lamp", 32'(la_flt), 32'h10);

        @(negedge clk) rst = 1'b1;
        #1;
        checkOutput("rst_async_flt", 32'(la_flt), 0);
        checkOutput("rst_async_perm", 32'(perm_bar), 1);
        @(negedge clk) rst = 1'b0;
        powerUp("pwr2");

        applyStimulus(8'hDF, 1'b0, 8'h00, 1'b0, 1'b0);
        expectDrop("ilk");
        waitCycles(3);
        checkOutput("ilk_lamp", 32'(la_ilk), 32'h20);
        applyStimulus(8'hFF, 1'b0, 8'h00, 1'b0, 1'b0);
        powerUp("pwr3");

        @(negedge clk) rst = 1'b1;
        em = 1'b1;
        @(negedge clk) rst = 1'b0;
        waitCycles(20);
        applyStimulus(8'hFF, 1'b1, 8'h00, 1'b0, 1'b1);
        waitCycles(4);
        checkOutput("lt_lamps", {14'd0, la_ilk, la_flt, la_em, la_ca_delay}, 32'h3FFFF);
        checkOutput("lt_enables", 32'(en_vec), 0);
        applyStimulus(8'hFF, 1'b1, 8'h00, 1'b0, 1'b0);
        waitCycles(4);
        checkOutput("lt_off_lamps", {14'd0, la_ilk, la_flt, la_em, la_ca_delay}, 32'h2);
        checkOutput("lt_off_enables", 32'(en_vec), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
